fp_multiplier: RTL and testbench

- Sequential IEEE-754 single-precision multiplier: Out = A × B.
- Uses an iterative shift-add 24×24 mantissa multiplier clocked by int_clk.
- An operation starts on a synchronously detected rising edge of the fp_clk strobe.
- Sits beside the FPU datapath; operands are held stable by the requester until the result is posted.

---
 rtl/fp_multiplier.sv | 238 +++++++++++++++++++++++
 tb/tb_fp_multiplier.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier.sv
// rtl/fp_multiplier.sv - iterative IEEE-754 single-precision multiplier
//
// Out = A * B, computed with a 24x24 shift-add mantissa multiplier that
// retires one multiplier bit per int_clk cycle. A multiply starts on a
// 0->1 transition of the fp_clk strobe, which is sampled on int_clk. Out is
// posted 26 cycles after the edge that samples the start, and done pulses
// for that one cycle.
//
// Ports:
//   int_clk  in   1  sole clock, rising edge
//   reset    in   1  synchronous, active-high; aborts any operation in flight
//   fp_clk   in   1  operation strobe (level signal, not a clock)
//   A, B     in  32  IEEE-754 single operands, latched at the start cycle
//   Out      out 32  registered product, held between updates
//   busy     out  1  high while an operation is in flight
//   done     out  1  one-cycle pulse when Out is updated
//
// Build option: define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise the result is truncated (round toward zero). Latency is the same
// in both builds.

module fp_multiplier (
    input  logic        int_clk,
    input  logic        reset,
    input  logic        fp_clk,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_PACK = 2'd3;

    logic [1:0]        state;
    logic              fp_clk_q;
    logic              start;

    logic [23:0]       a_man;
    logic [23:0]       b_man;
    logic [47:0]       acc;
    logic [4:0]        bit_idx;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [22:0]       frac_r;
    logic              special_r;
    logic [31:0]       special_word_r;

    assign start = fp_clk & ~fp_clk_q;

    // ------------------------------------------------------------------
    // Operand classification, evaluated on the live inputs and captured
    // only at the start cycle. Denormals have exp==0 and are therefore
    // classified as zero (flush-to-zero).
    // ------------------------------------------------------------------
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              sign_in;
    logic              special_hit;
    logic [31:0]       special_word;
    logic signed [9:0] exp_sum;

    assign ea      = A[30:23];
    assign eb      = B[30:23];
    assign fa      = A[22:0];
    assign fb      = B[22:0];
    assign sign_in = A[31] ^ B[31];

    assign a_zero  = (ea == 8'd0);
    assign b_zero  = (eb == 8'd0);
    assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);

    // Biased exponent of the product before normalisation; 10-bit signed so
    // both underflow (negative) and overflow (>255) stay representable.
    assign exp_sum = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;

    always_comb begin
        special_hit  = 1'b1;
        special_word = 32'd0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            special_word = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            special_word = {sign_in, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            special_word = {sign_in, 31'd0};
        end else begin
            special_hit  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Shift-add step: partial product for the current multiplier bit.
    // ------------------------------------------------------------------
    logic [47:0] partial;

    assign partial = {24'd0, a_man} << bit_idx;

    // ------------------------------------------------------------------
    // Normalisation and rounding of the finished 48-bit product.
    // The product of two 1.x mantissas lies in [1,4), so the leading one is
    // at bit 47 or bit 46.
    // ------------------------------------------------------------------
    logic [23:0]       mant;
    logic              guard;
    logic              sticky;
    logic signed [9:0] exp_norm;
    logic              round_up;
    logic [24:0]       mant_rnd;
    logic [22:0]       frac_final;
    logic signed [9:0] exp_final;

    always_comb begin
        if (acc[47]) begin
            mant     = acc[47:24];
            guard    = acc[23];
            sticky   = |acc[22:0];
            exp_norm = exp_r + 10'sd1;
        end else begin
            mant     = acc[46:23];
            guard    = acc[22];
            sticky   = |acc[21:0];
            exp_norm = exp_r;
        end
    end

`ifdef FP_MUL_ROUND_NEAREST_EN
    // Round up above the halfway point, or exactly at it when the kept LSB
    // is odd (ties to even).
    assign round_up = guard & (sticky | mant[0]);
`else
    assign round_up = 1'b0;
    logic  unused_round_bits;
    assign unused_round_bits = guard ^ sticky;
`endif

    // A carry out of the rounded mantissa means it became exactly 2.0:
    // the fraction is all zeros and the exponent moves up by one.
    assign mant_rnd   = {1'b0, mant} + {24'd0, round_up};
    assign frac_final = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
    assign exp_final  = mant_rnd[24] ? (exp_norm + 10'sd1) : exp_norm;

    // ------------------------------------------------------------------
    // Result packing with overflow / underflow saturation.
    // ------------------------------------------------------------------
    logic [31:0] packed_word;

    always_comb begin
        if (special_r) begin
            packed_word = special_word_r;
        end else if (exp_r >= 10'sd255) begin
            packed_word = {sign_r, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            packed_word = {sign_r, 31'd0};
        end else begin
            packed_word = {sign_r, exp_r[7:0], frac_r};
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: IDLE (start cycle S) -> MUL x24 -> NORM -> PACK (S+26).
    // ------------------------------------------------------------------
    always_ff @(posedge int_clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            fp_clk_q       <= 1'b0;
            Out            <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            a_man          <= 24'd0;
            b_man          <= 24'd0;
            acc            <= 48'd0;
            bit_idx        <= 5'd0;
            sign_r         <= 1'b0;
            exp_r          <= 10'sd0;
            frac_r         <= 23'd0;
            special_r      <= 1'b0;
            special_word_r <= 32'd0;
        end else begin
            fp_clk_q <= fp_clk;
            done     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // busy is low only in IDLE, so a start seen in any
                    // other state is dropped.
                    if (start) begin
                        a_man          <= {1'b1, fa};
                        b_man          <= {1'b1, fb};
                        sign_r         <= sign_in;
                        exp_r          <= exp_sum;
                        special_r      <= special_hit;
                        special_word_r <= special_word;
                        acc            <= 48'd0;
                        bit_idx        <= 5'd0;
                        busy           <= 1'b1;
                        state          <= ST_MUL;
                    end
                end

                ST_MUL: begin
                    if (b_man[bit_idx]) begin
                        acc <= acc + partial;
                    end
                    if (bit_idx == 5'd23) begin
                        state <= ST_NORM;
                    end else begin
                        bit_idx <= bit_idx + 5'd1;
                    end
                end

                ST_NORM: begin
                    exp_r  <= exp_final;
                    frac_r <= frac_final;
                    state  <= ST_PACK;
                end

                ST_PACK: begin
                    Out   <= packed_word;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_multiplier.sv
// tb/tb_fp_multiplier.sv - self-checking bench for fp_multiplier

module tb_fp_multiplier;

    logic        int_clk;
    logic        reset;
    logic        fp_clk;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Out;
    logic        busy;
    logic        done;

    fp_multiplier dut (
        .int_clk (int_clk),
        .reset   (reset),
        .fp_clk  (fp_clk),
        .A       (A),
        .B       (B),
        .Out     (Out),
        .busy    (busy),
        .done    (done)
    );

    initial int_clk = 1'b0;
    always #5 int_clk = ~int_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (timed out waiting for done)", name);
    endtask

    // Reference result straight from IEEE-754 arithmetic rules: exact
    // integer mantissa product, then normalise and round.
    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e, sh;
        logic [63:0] p, m;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
        e = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        m = p >> sh;
`ifdef FP_MUL_ROUND_NEAREST_EN
        begin
            logic [63:0] rem, half;
            rem  = p & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 64'd1;
            if (m == (64'd1 << 24)) begin
                m = m >> 1;
                e = e + 1;
            end
        end
`endif
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    // Cycle-level model of the observable contract: edge-detected start,
    // ignored while busy, result posted 26 edges later, reset aborts.
    int          cyc = 0;
    bit          live = 0;
    bit          pending = 0;
    bit          prev_strobe = 0;
    int          due_cyc = 0;
    int          start_cyc = 0;
    logic [31:0] pend_res = 0;
    logic [31:0] m_out = 0;
    bit          m_busy = 0;
    bit          m_done = 0;

    initial begin
        forever begin
            bit was_pending;
            @(posedge int_clk);
            cyc++;
            if (reset) begin
                live        = 1;
                pending     = 0;
                prev_strobe = 0;
                m_out       = 0;
                m_busy      = 0;
                m_done      = 0;
            end else if (live) begin
                m_done      = 0;
                was_pending = pending;
                if (pending && cyc == due_cyc) begin
                    m_out   = pend_res;
                    m_done  = 1;
                    pending = 0;
                end
                if (fp_clk && !prev_strobe && !was_pending) begin
                    pending   = 1;
                    due_cyc   = cyc + 26;
                    start_cyc = cyc;
                    pend_res  = model_mul(A, B);
                end
                prev_strobe = fp_clk;
                m_busy      = pending;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    int done_count = 0;
    int last_done_cyc = 0;

    initial begin
        forever begin
            @(negedge int_clk);
            if (live) begin
                check("out_vs_model", Out, m_out);
                check("busy_vs_model", {31'd0, busy}, {31'd0, m_busy});
                check("done_vs_model", {31'd0, done}, {31'd0, m_done});
                if (done) begin
                    done_count++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(negedge int_clk);
        #1;
    endtask

    task automatic wait_done(input int d0, input string name, input logic [31:0] exp);
        int n;
        n = 0;
        while (done_count == d0 && n < 40) begin
            tick();
            n++;
        end
        if (done_count == d0) begin
            note_fail(name);
        end else begin
            check(name, Out, exp);
            check({name, "_latency"}, 32'(last_done_cyc - start_cyc), 32'd26);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input string name);
        int d0;
        tick();
        fp_clk = 1'b0;
        A      = a;
        B      = b;
        tick();
        fp_clk = 1'b1;
        d0     = done_count;
        wait_done(d0, name, exp);
    endtask

    logic [31:0] vec_a [14] = '{32'h40A00000, 32'h40A00000, 32'hC0A00000, 32'h40B00000,
                                32'h40B00000, 32'h40B00000, 32'hC0B00000, 32'h7F800000,
                                32'h7F000000, 32'h00000000, 32'h00000001, 32'h7FC00001,
                                32'h00800000, 32'hFF800000};
    logic [31:0] vec_b [14] = '{32'h3F800000, 32'hC0000000, 32'hC0000000, 32'h40300000,
                                32'h3F800000, 32'hC0300000, 32'hC0300000, 32'h00000000,
                                32'h40000000, 32'hC0000000, 32'h40000000, 32'h3F800000,
                                32'h00800000, 32'h40000000};
    logic [31:0] vec_e [14] = '{32'h40A00000, 32'hC1200000, 32'h41200000, 32'h41720000,
                                32'h40B00000, 32'hC1720000, 32'h41720000, 32'h7FC00000,
                                32'h7F800000, 32'h80000000, 32'h00000000, 32'h7FC00000,
                                32'h00000000, 32'hFF800000};

    initial begin
        int d0;

        // Pin the model itself with hand-computed products.
        check("model_5x2", model_mul(32'h40A00000, 32'h40000000), 32'h41200000);
        check("model_5.5x2.75", model_mul(32'h40B00000, 32'h40300000), 32'h41720000);
        check("model_inf_x0", model_mul(32'h7F800000, 32'h00000000), 32'h7FC00000);
        check("model_ovf", model_mul(32'h7F000000, 32'h40000000), 32'h7F800000);
        check("model_negzero", model_mul(32'h00000000, 32'hC0000000), 32'h80000000);

        // Reset with the strobe already high: first cycle after reset starts.
        reset  = 1'b1;
        fp_clk = 1'b1;
        A      = 32'h40A00000;
        B      = 32'h40000000;
        repeat (3) tick();
        check("reset_out", Out, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        d0     = done_count;
        reset  = 1'b0;
        repeat (50) tick();
        check("first_op_done_count", 32'(done_count - d0), 32'd1);
        check("first_op_out", Out, 32'h41200000);
        check("first_op_latency", 32'(last_done_cyc - start_cyc), 32'd26);

        for (int i = 0; i < 14; i++) begin
            run_op(vec_a[i], vec_b[i], vec_e[i], $sformatf("vec%0d", i));
        end

        // Strobe held high: no second start.
        d0 = done_count;
        repeat (60) tick();
        check("held_strobe_no_restart", 32'(done_count - d0), 32'd0);

        // Operands change mid-operation: latched values are used.
        fp_clk = 1'b0;
        A      = 32'h40A00000;
        B      = 32'h40000000;
        tick();
        fp_clk = 1'b1;
        d0     = done_count;
        repeat (5) tick();
        A = 32'h40B00000;
        B = 32'h3F800000;
        wait_done(d0, "operand_change", 32'h41200000);

        // Second rising edge while busy is ignored.
        fp_clk = 1'b0;
        A      = 32'h40B00000;
        B      = 32'h40300000;
        tick();
        fp_clk = 1'b1;
        d0     = done_count;
        repeat (3) tick();
        fp_clk = 1'b0;
        repeat (2) tick();
        A      = 32'h3F800000;
        fp_clk = 1'b1;
        wait_done(d0, "start_while_busy", 32'h41720000);
        d0 = done_count;
        repeat (40) tick();
        check("busy_start_dropped", 32'(done_count - d0), 32'd0);

        // Reset mid-operation aborts without a done pulse.
        fp_clk = 1'b0;
        A      = 32'h40A00000;
        B      = 32'h40000000;
        tick();
        fp_clk = 1'b1;
        d0     = done_count;
        repeat (10) tick();
        reset  = 1'b1;
        fp_clk = 1'b0;
        tick();
        reset  = 1'b0;
        check("abort_out", Out, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) tick();
        check("abort_no_done", 32'(done_count - d0), 32'd0);
        run_op(32'h40B00000, 32'hC0300000, 32'hC1720000, "after_abort");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog (simulation did not finish)");
        $fatal(1);
    end

endmodule
